// File: rtl/frame_capture_bram0.sv
// frame_capture_bram0: captures one raster frame from a valid/ready pixel
// stream into BRAM0 port 0. It then pulses o_complete together with the
// last-pixel address for the downstream Sobel FSM.
// Optional feature: define FRAME_CAPTURE_LINE_CHECK_EN to flag an s_eol that
// disagrees with the column count in o_err. Addressing is not affected.
module frame_capture_bram0 #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 12,
  parameter int IMAGE_WIDTH  = 64,
  parameter int IMAGE_HEIGHT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_consumer_idle,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  s_eol,
  output logic                  s_ready,
  output logic                  b0_ce0,
  output logic                  b0_we0,
  output logic [ADDR_WIDTH-1:0] b0_addr0,
  output logic [DATA_WIDTH-1:0] b0_d0,
  output logic                  o_complete,
  output logic [ADDR_WIDTH-1:0] o_num_cnt,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam logic [ADDR_WIDTH-1:0] COL_LAST  = ADDR_WIDTH'(IMAGE_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST  = ADDR_WIDTH'(IMAGE_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] PIX_LAST  = ADDR_WIDTH'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1'b1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] pix_addr_r;
  logic [ADDR_WIDTH-1:0] col_cnt_r;
  logic [ADDR_WIDTH-1:0] row_cnt_r;

  logic                  accept_s;
  logic                  resync_s;
  logic                  last_s;
  logic                  line_err_s;
  logic [ADDR_WIDTH-1:0] beat_addr_s;
  logic [ADDR_WIDTH-1:0] beat_col_s;
  logic [ADDR_WIDTH-1:0] beat_row_s;

  assign accept_s = s_valid & s_ready;

`ifndef FRAME_CAPTURE_LINE_CHECK_EN
  logic unused_eol_s;
  assign unused_eol_s = s_eol;
`endif

  // Raster position of the current beat; an SOF always restarts the frame at pixel 0
  always_comb begin
    beat_addr_s = pix_addr_r;
    beat_col_s  = col_cnt_r;
    beat_row_s  = row_cnt_r;
    resync_s    = 1'b0;
    line_err_s  = 1'b0;
    if (s_sof) begin
      beat_addr_s = ADDR_ZERO;
      beat_col_s  = ADDR_ZERO;
      beat_row_s  = ADDR_ZERO;
      resync_s    = (state_r == CAPTURE);
    end else begin
      beat_addr_s = pix_addr_r;
      beat_col_s  = col_cnt_r;
      beat_row_s  = row_cnt_r;
    end
`ifdef FRAME_CAPTURE_LINE_CHECK_EN
    if (state_r == CAPTURE) begin
      line_err_s = (s_eol != (beat_col_s == COL_LAST));
    end else begin
      line_err_s = 1'b0;
    end
`endif
    last_s = (beat_row_s == ROW_LAST) && (beat_col_s == COL_LAST);
  end

  // Capture FSM with registered handshake, BRAM write port and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      pix_addr_r <= ADDR_ZERO;
      col_cnt_r  <= ADDR_ZERO;
      row_cnt_r  <= ADDR_ZERO;
      s_ready    <= 1'b0;
      b0_ce0     <= 1'b0;
      b0_we0     <= 1'b0;
      b0_addr0   <= ADDR_ZERO;
      b0_d0      <= {DATA_WIDTH{1'b0}};
      o_complete <= 1'b0;
      o_num_cnt  <= ADDR_ZERO;
      o_busy     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      b0_ce0     <= 1'b0;
      b0_we0     <= 1'b0;
      o_complete <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_start && i_consumer_idle) begin
            state_r    <= WAIT_SOF;
            s_ready    <= 1'b1;
            o_busy     <= 1'b1;
            o_err      <= 1'b0;
            o_num_cnt  <= ADDR_ZERO;
            pix_addr_r <= ADDR_ZERO;
            col_cnt_r  <= ADDR_ZERO;
            row_cnt_r  <= ADDR_ZERO;
          end else begin
            s_ready <= 1'b0;
            o_busy  <= 1'b0;
          end
        end
        WAIT_SOF, CAPTURE: begin
          // Beats before the first SOF are dropped without a write
          if (accept_s && (s_sof || (state_r == CAPTURE))) begin
            b0_ce0   <= 1'b1;
            b0_we0   <= 1'b1;
            b0_addr0 <= beat_addr_s;
            b0_d0    <= s_data;
            if (resync_s || line_err_s) begin
              o_err <= 1'b1;
            end else begin
              o_err <= o_err;
            end
            if (last_s) begin
              state_r   <= DONE;
              s_ready   <= 1'b0;
              o_num_cnt <= PIX_LAST;
            end else begin
              state_r    <= CAPTURE;
              pix_addr_r <= beat_addr_s + ADDR_ONE;
              if (beat_col_s == COL_LAST) begin
                col_cnt_r <= ADDR_ZERO;
                row_cnt_r <= beat_row_s + ADDR_ONE;
              end else begin
                col_cnt_r <= beat_col_s + ADDR_ONE;
                row_cnt_r <= beat_row_s;
              end
            end
          end else begin
            state_r <= state_r;
          end
        end
        DONE: begin
          // Final write committed last cycle; now signal the consumer
          state_r    <= IDLE;
          s_ready    <= 1'b0;
          o_busy     <= 1'b0;
          o_complete <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          s_ready <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/frame_capture_bram0.md
# frame_capture_bram0

Upstream capture stage for the Sobel edge-detector path. Accepts a raster pixel stream with a valid/ready handshake, writes one full frame into BRAM0 through its write port (port 0), then pulses the frame-complete strobe together with the last-pixel address. The downstream Sobel FSM consumes these as its completion flag and frame count. The block only re-arms when the downstream engine reports idle, so a frame being read is never overwritten.

## Interface
- DATA_WIDTH, 8, pixel width
- ADDR_WIDTH, 12, BRAM0 address width
- IMAGE_WIDTH, 64, pixels per line
- IMAGE_HEIGHT, 64, lines per frame; IMAGE_WIDTH*IMAGE_HEIGHT must be ≤ 2^ADDR_WIDTH

Ports:
- clk  in  1  single clock
- rst  in  1  reset: synchronous, active-high
- i_start  in  1  arm request for a capture
- i_consumer_idle  in  1  downstream Sobel FSM idle (its o_idle)
- s_valid  in  1  pixel beat valid
- s_data  in  DATA_WIDTH  pixel value
- s_sof  in  1  beat is first pixel of frame
- s_eol  in  1  beat is last pixel of a line
- s_ready  out  1  beat accepted when s_valid & s_ready
- b0_ce0  out  1  BRAM0 port-0 enable
- b0_we0  out  1  BRAM0 port-0 write enable
- b0_addr0  out  ADDR_WIDTH  write address
- b0_d0  out  DATA_WIDTH  write data
- o_complete  out  1  one-cycle frame-stored pulse (to i_complete)
- o_num_cnt  out  ADDR_WIDTH  last written address, IMAGE_WIDTH*IMAGE_HEIGHT-1 (to i_num_cnt)
- o_busy  out  1  state ≠ IDLE
- o_err  out  1  sticky framing error

## Operation
- States: IDLE, WAIT_SOF, CAPTURE, DONE. Encoding is 2 bits.
- IDLE:
  - s_ready=0.
  - Go to WAIT_SOF when i_start & i_consumer_idle.
  - The arm clears o_err and the pixel, column and row counters.
  - i_start while not idle, or while i_consumer_idle=0, is ignored and is not queued.
- WAIT_SOF:
  - s_ready=1.
  - Accepted beats with s_sof=0 are discarded; nothing is written.
  - An accepted beat with s_sof=1 is written to address 0, then the state goes to CAPTURE.
- CAPTURE:
  - s_ready=1.
  - Every accepted beat is written to pix_addr, which increments by 1 per beat.
  - col_cnt wraps at IMAGE_WIDTH-1 and then increments row_cnt.
  - If s_sof=1 mid-frame, the block resyncs: the beat is written to address 0, counters restart from that beat, and o_err is set.
  - When the beat at pix_addr = IMAGE_WIDTH*IMAGE_HEIGHT-1 is accepted, the state goes to DONE.
- DONE:
  - s_ready=0.
  - Lasts exactly one cycle, then the state returns to IDLE.
- o_num_cnt is loaded with IMAGE_WIDTH*IMAGE_HEIGHT-1 on entry to DONE and held until the next arm.
- Address arithmetic is ADDR_WIDTH unsigned. pix_addr never exceeds the last-pixel index, so there is no wrap.
- Reset mid-frame:
  - All state returns to IDLE and every output returns to its reset value.
  - No o_complete is produced.
  - Partially written BRAM contents are don't-care.

## Timing
- Reset values:
  - s_ready=0, b0_ce0=0, b0_we0=0, b0_addr0=0, b0_d0=0.
  - o_complete=0, o_num_cnt=0, o_busy=0, o_err=0.
- Arm: i_start sampled at cycle t moves the state to WAIT_SOF, so s_ready=1 from t+1.
- Write latency: a beat accepted at cycle t is written at t+1.
  - At t+1: b0_ce0=b0_we0=1, with registered b0_addr0/b0_d0.
  - With no accepted beat at t, b0_ce0=b0_we0=0 at t+1.
- Final beat accepted at t:
  - t+1: state=DONE, the last write is on the port, s_ready=0.
  - t+2: o_complete=1 for one cycle; state=IDLE.
  - This guarantees the final BRAM write has committed before the downstream FSM sees i_complete.
- No back-pressure inside a frame apart from DONE/IDLE; throughput is one pixel per clock.
- s_valid gaps are allowed at any point; the counters hold.

## Configuration
- FRAME_CAPTURE_LINE_CHECK_EN defined:
  - On each CAPTURE beat, s_eol must equal (col_cnt == IMAGE_WIDTH-1).
  - A mismatch sets o_err. Addressing is unaffected; there is no resync on s_eol.
- Not defined: s_eol is ignored entirely, and o_err is set only by a mid-frame s_sof.

## Test plan
- Nominal frame:
  - Stimulus: reset, i_consumer_idle=1, pulse i_start, then 4096 contiguous beats with data = addr[7:0] and s_sof on the first.
  - Required: 4096 writes to addresses 0..4095; o_complete is one pulse 2 cycles after the last accept; o_num_cnt=4095; o_err=0.
- Leading garbage:
  - Stimulus: 5 beats with s_sof=0 before the SOF beat.
  - Required: no writes for those 5 beats; the SOF pixel lands at address 0.
- Arm gating:
  - Stimulus: i_start with i_consumer_idle=0.
  - Required: stays IDLE with s_ready=0. After raising i_consumer_idle, a new i_start arms.
- Mid-frame SOF:
  - Stimulus: s_sof at beat 100.
  - Required: that beat is written at address 0, o_err=1, and o_complete arrives after 4096 further beats counted from it.
- Line check (FRAME_CAPTURE_LINE_CHECK_EN):
  - Stimulus: s_eol asserted at col 62.
  - Required: o_err=1; addresses remain sequential. Without the macro, o_err=0.
- Reset mid-frame:
  - Stimulus: rst at beat 2000, then a new full frame.
  - Required: all outputs 0 after reset, no o_complete for the aborted frame, and the new frame completes normally.
